// File: rtl/requant_pkg.sv
// Shared widths, configuration record and saturation helper for the int32 -> uint8 requantizer.
package requant_pkg;

    localparam int ACC_W   = 32;
    localparam int OUT_W   = 8;
    localparam int MULT_W  = 31;
    localparam int SHIFT_W = 4;

    typedef struct packed {
        logic signed [ACC_W-1:0] bias;
        logic [MULT_W-1:0]       mult;
        logic [SHIFT_W-1:0]      shift;
        logic [OUT_W-1:0]        zp;
    } requant_cfg_t;

    // The two top bits of a 33-bit sum differ exactly when it left the int32 range.
    function automatic logic signed [ACC_W-1:0] sat_33_to_32(input logic signed [ACC_W:0] x);
        if (x[ACC_W] != x[ACC_W-1])
            return x[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        return x[ACC_W-1:0];
    endfunction

endpackage

// File: rtl/requant_round_clamp.sv
// Combinational final stage: round-half-up right shift by 31+shift, zero-point add, clamp to uint8.
module requant_round_clamp
    import requant_pkg::*;
(
    input  logic signed [2*ACC_W-1:0] prod,
    input  logic [SHIFT_W-1:0]        shift,
    input  logic [OUT_W-1:0]          zp,
    output logic [OUT_W-1:0]          data
);

    // Two guard bits keep the rounding add and the zero-point add free of wrap.
    localparam int EXT_W = 2*ACC_W + 2;

    logic [5:0]              sh;
    logic signed [EXT_W-1:0] rounded;
    logic signed [EXT_W-1:0] shifted;
    logic signed [EXT_W-1:0] v;

    always_comb begin
        sh      = 6'd31 + {2'b00, shift};
        rounded = EXT_W'(prod) + (EXT_W'(1) <<< (sh - 6'd1));
        shifted = rounded >>> sh;
        v       = shifted + EXT_W'($signed({1'b0, zp}));
        if (v < 0)
            data = '0;
        else if (v > EXT_W'(255))
            data = '1;
        else
            data = v[OUT_W-1:0];
    end

endmodule

// File: rtl/requant_int32_uint8.sv
// Three-stage requantizer (bias+saturate, Q0.31 multiply, round/clamp) with valid/ready on both sides.
module requant_int32_uint8
    import requant_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ACC_W-1:0]   in_acc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    input  logic               cfg_we,
    input  logic [ACC_W-1:0]   cfg_bias,
    input  logic [MULT_W-1:0]  cfg_mult,
    input  logic [SHIFT_W-1:0] cfg_shift,
    input  logic [OUT_W-1:0]   cfg_zp,
    output logic               busy,
    output logic               cfg_err
);

    requant_cfg_t cfg;

    logic                      advance;
    logic                      s1_valid;
    logic                      s2_valid;
    logic signed [ACC_W-1:0]   s1_sum;
    logic signed [2*ACC_W-1:0] s2_prod;
    logic signed [ACC_W:0]     bias_sum;
    logic signed [2*ACC_W-1:0] sum_ext;
    logic signed [2*ACC_W-1:0] mult_ext;
    logic [OUT_W-1:0]          s3_data;

    // Every stage shares one enable, so a stalled output freezes the whole pipe.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign busy     = s1_valid | s2_valid | out_valid;

    assign bias_sum = {in_acc[ACC_W-1], in_acc} + {cfg.bias[ACC_W-1], cfg.bias};
    assign sum_ext  = (2*ACC_W)'(s1_sum);
    assign mult_ext = (2*ACC_W)'($signed({1'b0, cfg.mult}));

    // Writes are only taken with the pipe empty, so no beat ever sees a mixed configuration.
    always_ff @(posedge clock) begin
        if (reset) begin
            cfg     <= '0;
            cfg_err <= 1'b0;
        end else if (cfg_we) begin
            if (!busy && !in_valid)
                cfg <= '{bias: cfg_bias, mult: cfg_mult, shift: cfg_shift, zp: cfg_zp};
            else
                cfg_err <= 1'b1;
        end
    end

    requant_round_clamp u_round_clamp (
        .prod  (s2_prod),
        .shift (cfg.shift),
        .zp    (cfg.zp),
        .data  (s3_data)
    );

    // NOTE: data registers are reset too so out_data reads 0 after reset, not just the valid bits.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            s1_sum    <= '0;
            s2_prod   <= '0;
            out_data  <= '0;
        end else if (advance) begin
            s1_valid  <= in_valid;
            s1_sum    <= sat_33_to_32(bias_sum);
            s2_valid  <= s1_valid;
            s2_prod   <= sum_ext * mult_ext;
            out_valid <= s2_valid;
            out_data  <= s3_data;
        end
    end

endmodule

// File: tb/tb_requant_int32_uint8.sv
// Randomised and directed bench for requant_int32_uint8 against an arithmetic reference model.
module tb_requant_int32_uint8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_acc = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_data;
    logic        cfg_we = 1'b0;
    logic [31:0] cfg_bias = '0;
    logic [30:0] cfg_mult = '0;
    logic [3:0]  cfg_shift = '0;
    logic [7:0]  cfg_zp = '0;
    logic        busy;
    logic        cfg_err;

    int total = 0;
    int bad = 0;

    // Configuration the model believes the DUT holds.
    int          m_bias = 0;
    int unsigned m_mult = 0;
    int          m_shift = 0;
    int          m_zp = 0;

    int exp_q[$];
    int got_q[$];

    requant_int32_uint8 dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_acc    (in_acc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cfg_we    (cfg_we),
        .cfg_bias  (cfg_bias),
        .cfg_mult  (cfg_mult),
        .cfg_shift (cfg_shift),
        .cfg_zp    (cfg_zp),
        .busy      (busy),
        .cfg_err   (cfg_err)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int ref_out(int acc, int bias, int unsigned mult, int shift, int zp);
        longint sum, prod, d, num, r, v;
        sum = longint'(acc) + longint'(bias);
        if (sum > 64'sd2147483647) sum = 64'sd2147483647;
        else if (sum < -64'sd2147483648) sum = -64'sd2147483648;
        prod = sum * longint'(mult);
        d = longint'(1) << (31 + shift);
        num = prod + d / 2;
        if (num >= 0) r = num / d;
        else r = -((-num + d - 1) / d);
        v = r + zp;
        if (v < 0) return 0;
        if (v > 255) return 255;
        return int'(v);
    endfunction

    // Transfers are sampled mid-cycle, where inputs and outputs are both settled.
    always @(negedge clock) begin
        if (!reset) begin
            if (in_valid && in_ready) exp_q.push_back(ref_out(int'(in_acc), m_bias, m_mult, m_shift, m_zp));
            if (out_valid && out_ready) got_q.push_back(int'(out_data));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic cfg_write(input int bias, input int unsigned mult, input int shift, input int zp);
        cfg_we = 1'b1;
        cfg_bias = bias;
        cfg_mult = mult[30:0];
        cfg_shift = shift[3:0];
        cfg_zp = zp[7:0];
        tick();
        cfg_we = 1'b0;
        m_bias = bias;
        m_mult = mult;
        m_shift = shift;
        m_zp = zp;
    endtask

    task automatic send(input int acc);
        int n;
        logic ok;
        n = 0;
        ok = 1'b0;
        in_valid = 1'b1;
        in_acc = acc;
        do begin
            @(negedge clock);
            ok = in_ready;
            tick();
            n++;
        end while (!ok && n < 200);
        in_valid = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready never seen high for acc=%0d", acc);
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((busy || got_q.size() < exp_q.size()) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) begin
            total++;
            bad++;
            $display("FAIL %s_drain_timeout: got %0d beats, wanted %0d", name, got_q.size(), exp_q.size());
        end
    endtask

    task automatic clear_queues();
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (out_data !== 8'd0) begin bad++; $display("FAIL reset_out_data: got %0d want 0", out_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL reset_cfg_err: got %b want 0", cfg_err); end
    endtask

    task automatic test_basic_scaling();
        int want[2];
        clear_queues();
        out_ready = 1'b1;
        cfg_write(0, 32'd1 << 30, 0, 0);
        // Latency: acceptance edge, then two more edges before out_valid rises.
        in_valid = 1'b1;
        in_acc = 100;
        @(negedge clock);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL lat_in_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_edge1_valid: got %b want 0", out_valid); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_edge2_valid: got %b want 0", out_valid); end
        tick();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL lat_edge3_valid: got %b want 1", out_valid); end
        total++; if (out_data !== 8'd50) begin bad++; $display("FAIL lat_data_100: got %0d want 50", out_data); end
        drain("lat");
        clear_queues();
        send(101);
        send(-3);
        drain("basic");
        want = '{51, 0};
        total++;
        if (got_q.size() != 2) begin bad++; $display("FAIL basic_count: got %0d want 2", got_q.size()); end
        else for (int i = 0; i < 2; i++) begin
            if (i > 0) total++;
            if (got_q[i] !== want[i]) begin bad++; $display("FAIL basic_beat%0d: got %0d want %0d", i, got_q[i], want[i]); end
        end
    endtask

    task automatic test_zero_point_clamp();
        int want[2];
        clear_queues();
        cfg_write(0, 32'd1 << 30, 0, 128);
        send(-3);
        send(400);
        drain("zp");
        want = '{127, 255};
        total++;
        if (got_q.size() != 2) begin bad++; $display("FAIL zp_count: got %0d want 2", got_q.size()); end
        else for (int i = 0; i < 2; i++) begin
            if (i > 0) total++;
            if (got_q[i] !== want[i]) begin bad++; $display("FAIL zp_beat%0d: got %0d want %0d", i, got_q[i], want[i]); end
        end
    endtask

    task automatic test_bias_saturation();
        clear_queues();
        cfg_write(32'h0000_0100, 32'h7FFF_FFFF, 0, 0);
        send(32'h7FFF_FFF0);
        drain("sat_hi");
        total++;
        if (got_q.size() != 1 || got_q[0] !== 255) begin
            bad++; $display("FAIL sat_high: got %0d (n=%0d) want 255", got_q.size() ? got_q[0] : -1, got_q.size());
        end
        clear_queues();
        cfg_write(-1, 32'h7FFF_FFFF, 0, 0);
        send(32'h8000_0000);
        drain("sat_lo");
        total++;
        if (got_q.size() != 1 || got_q[0] !== 0) begin
            bad++; $display("FAIL sat_low: got %0d (n=%0d) want 0", got_q.size() ? got_q[0] : -1, got_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int bias;
        clear_queues();
        bias = int'($urandom_range(200, 0)) - 100;
        cfg_write(bias, $urandom_range(32'h4000_0000, 32'h1000_0000), $urandom_range(3, 0), $urandom_range(255, 0));
        out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++) send(int'($urandom_range(1200, 0)) - 600);
            end
            begin
                int n;
                logic [7:0] held;
                n = 0;
                while (!out_valid && n < 50) begin tick(); n++; end
                total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_first_valid: got %b want 1", out_valid); end
                out_ready = 1'b0;
                held = out_data;
                for (int c = 0; c < 5; c++) begin
                    #1;
                    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready_c%0d: got %b want 0", c, in_ready); end
                    tick();
                    total++;
                    if (out_valid !== 1'b1 || out_data !== held) begin
                        bad++; $display("FAIL bp_hold_c%0d: valid=%b data=%0d want valid=1 data=%0d", c, out_valid, out_data, held);
                    end
                end
                out_ready = 1'b1;
            end
        join
        drain("bp");
        total++;
        if (got_q.size() != 8 || exp_q.size() != 8) begin
            bad++; $display("FAIL bp_count: got %0d model %0d want 8", got_q.size(), exp_q.size());
        end else for (int i = 0; i < 8; i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL bp_beat%0d: got %0d want %0d", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_cfg_gating();
        clear_queues();
        out_ready = 1'b1;
        cfg_write(0, 32'd1 << 30, 0, 10);
        fork
            begin
                for (int i = 0; i < 6; i++) send(200 + 16 * i);
            end
            begin
                tick();
                tick();
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL gate_busy: got %b want 1", busy); end
                cfg_we = 1'b1;
                cfg_bias = '0;
                cfg_mult = 31'h4000_0000;
                cfg_shift = 4'd2;
                cfg_zp = 8'd10;
                tick();
                cfg_we = 1'b0;
                total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL gate_cfg_err: got %b want 1", cfg_err); end
            end
        join
        drain("gate");
        total++;
        if (got_q.size() != 6 || exp_q.size() != 6) begin
            bad++; $display("FAIL gate_count: got %0d model %0d want 6", got_q.size(), exp_q.size());
        end else for (int i = 0; i < 6; i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL gate_beat%0d: got %0d want %0d", i, got_q[i], exp_q[i]); end
        end
        clear_queues();
        cfg_write(0, 32'd1 << 30, 2, 10);
        send(200);
        drain("gate_new");
        total++;
        if (got_q.size() != 1 || got_q[0] !== 35) begin
            bad++; $display("FAIL gate_new_shift: got %0d (n=%0d) want 35", got_q.size() ? got_q[0] : -1, got_q.size());
        end
        total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL gate_err_sticky: got %b want 1", cfg_err); end
    endtask

    task automatic test_reset_midstream();
        clear_queues();
        cfg_write(50, 32'h3000_0000, 1, 77);
        out_ready = 1'b0;
        send(1000);
        send(-1000);
        send(5000);
        total++; if (busy !== 1'b1 || out_valid !== 1'b1) begin bad++; $display("FAIL rst_inflight: busy=%b valid=%b want 1 1", busy, out_valid); end
        reset = 1'b1;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_out_valid: got %b want 0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL rst_mid_cfg_err: got %b want 0", cfg_err); end
        reset = 1'b0;
        m_bias = 0; m_mult = 0; m_shift = 0; m_zp = 0;
        clear_queues();
        out_ready = 1'b1;
        repeat (6) tick();
        total++; if (got_q.size() != 0) begin bad++; $display("FAIL rst_stale_beats: got %0d want 0", got_q.size()); end
        send(1000);
        drain("rst");
        total++;
        if (got_q.size() != 1 || got_q[0] !== 0) begin
            bad++; $display("FAIL rst_cfg_zeroed: got %0d (n=%0d) want 0", got_q.size() ? got_q[0] : -1, got_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic_scaling();
        test_zero_point_clamp();
        test_bias_saturation();
        test_back_to_back();
        test_cfg_gating();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
